// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Bundles the receiver-side handshake (rx_rdy/rx_data/rx_rdy_clr), the
//   host-side show-ahead stream (m_data/m_valid/m_ready) and the status and
//   control signals of the receive buffer.
// Ports (signals)
//   rx_rdy      receiver byte-ready level, held until cleared
//   rx_data     receiver byte, valid while rx_rdy=1
//   rx_rdy_clr  one-cycle clear pulse back to the receiver
//   m_data      head-of-queue byte
//   m_valid     m_data holds a valid byte
//   m_ready     host accepts m_data
//   count       entries stored, 0..2**AW
//   full/empty  fill status
//   overflow    sticky dropped-byte flag
//   ovf_clr     clears overflow
// Modports
//   slave  : buffer side (drives rx_rdy_clr, host stream and status)
//   master : environment side (receiver + host)
interface uart_rx_fifo_if #(
   parameter int AW = 4
);
   logic          rx_rdy;
   logic [7:0]    rx_data;
   logic          rx_rdy_clr;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_ready;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          ovf_clr;

   modport slave (
      input  rx_rdy, rx_data, m_ready, ovf_clr,
      output rx_rdy_clr, m_data, m_valid, count, full, empty, overflow
   );

   modport master (
      output rx_rdy, rx_data, m_ready, ovf_clr,
      input  rx_rdy_clr, m_data, m_valid, count, full, empty, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer sitting directly behind a UART receiver. Each
//   byte presented on rx_rdy/rx_data is captured once and acknowledged with a
//   single-cycle rx_rdy_clr pulse, queued in a DEPTH-entry FIFO and offered
//   to the host on a show-ahead valid/ready stream. Reports fill level,
//   full/empty and a sticky overflow flag.
// Parameters
//   DEPTH  FIFO entries, power of 2, >= 2
//   AW     log2(DEPTH)
// Ports
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_fifo_if.slave (see interface header for signal list)
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_rx_fifo_if.slave bus
);

   logic [AW:0]  wr_ptr_reg;
   logic [AW:0]  rd_ptr_reg;
   logic         rx_rdy_clr_reg;
   logic         overflow_reg;
   logic [7:0]   mem_rd [DEPTH];

   logic         cap;
   logic         push;
   logic         pop;
   logic         drop;
   logic         full;
   logic         empty;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   assign wr_idx = wr_ptr_reg[AW-1:0];
   assign rd_idx = rd_ptr_reg[AW-1:0];

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);

   // rx_rdy stays high for a cycle after our clear pulse; masking with the
   // pulse itself keeps one byte from being captured twice.
   assign cap  = bus.rx_rdy & ~rx_rdy_clr_reg;
   assign pop  = ~empty & bus.m_ready;
   // When full, a simultaneous pop frees the head slot, which is exactly the
   // slot the write pointer aliases, so the push can still be accepted.
   assign push = cap & (~full | pop);
   assign drop = cap & full & ~pop;

   // Storage: one register per entry so the whole array clears on reset and
   // the head byte is readable combinationally for show-ahead output.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_mem
         logic [7:0] entry_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_reg <= '0;
            end else if (push && (wr_idx == AW'(gi))) begin
               entry_reg <= bus.rx_data;
            end
         end
         assign mem_rd[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         rx_rdy_clr_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         // Pulse on every capture, including dropped bytes, so the receiver
         // never stalls waiting for a clear.
         rx_rdy_clr_reg <= cap;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
         end
         // A drop on the same edge as ovf_clr wins.
         if (drop) begin
            overflow_reg <= 1'b1;
         end else if (bus.ovf_clr) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   assign bus.rx_rdy_clr = rx_rdy_clr_reg;
   assign bus.m_data     = mem_rd[rd_idx];
   assign bus.m_valid    = ~empty;
   assign bus.count      = wr_ptr_reg - rd_ptr_reg;
   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed self-checking bench for uart_rx_fifo. Inputs change and outputs
//   are sampled 1 time unit after each rising clock edge.
module tb_uart_rx_fifo;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   uart_rx_fifo_if #(.AW(4)) bus ();

   uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Receiver model: raise rdy with a byte, drop it after the capture edge.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_rdy  = 1'b1;
      bus.rx_data = b;
      step();
      bus.rx_rdy  = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.rx_rdy  = 1'b0;
      bus.rx_data = 8'h00;
      bus.m_ready = 1'b0;
      bus.ovf_clr = 1'b0;
      #13;
      checks++;
      if ({bus.rx_rdy_clr, bus.m_valid, bus.empty, bus.full, bus.overflow} !== 5'b00100) begin
         failures++;
         $display("FAIL reset_flags got clr,valid,empty,full,ovf=%b want 00100",
                  {bus.rx_rdy_clr, bus.m_valid, bus.empty, bus.full, bus.overflow});
      end
      checks++;
      if (bus.count !== 5'd0 || bus.m_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_count_data got count=%0d data=%h want 0 00", bus.count, bus.m_data);
      end
      rst_n = 1'b1;
      step();
      $display("reset: count=%0d empty=%b", bus.count, bus.empty);
   endtask

   task automatic test_single();
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'hA5;
      step();
      checks++;
      if (bus.rx_rdy_clr !== 1'b1 || bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5 || bus.count !== 5'd1) begin
         failures++;
         $display("FAIL single_capture got clr=%b valid=%b data=%h count=%0d want 1 1 a5 1",
                  bus.rx_rdy_clr, bus.m_valid, bus.m_data, bus.count);
      end
      bus.rx_rdy = 1'b0;
      step();
      checks++;
      if (bus.rx_rdy_clr !== 1'b0 || bus.count !== 5'd1) begin
         failures++;
         $display("FAIL single_pulse_end got clr=%b count=%0d want 0 1", bus.rx_rdy_clr, bus.count);
      end
      bus.m_ready = 1'b1;
      step();
      checks++;
      if (bus.empty !== 1'b1 || bus.m_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_pop got empty=%b valid=%b want 1 0", bus.empty, bus.m_valid);
      end
      // m_ready with nothing queued must not move the pointers.
      step();
      checks++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
         failures++;
         $display("FAIL ready_when_empty got count=%0d empty=%b want 0 1", bus.count, bus.empty);
      end
      bus.m_ready = 1'b0;
      $display("single: byte a5 captured and popped");
   endtask

   task automatic test_late_clear();
      int pulses;
      pulses      = 0;
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'h3C;
      for (int i = 0; i < 2; i++) begin
         step();
         if (bus.rx_rdy_clr === 1'b1) pulses++;
      end
      bus.rx_rdy = 1'b0;
      step();
      if (bus.rx_rdy_clr === 1'b1) pulses++;
      checks++;
      if (pulses != 1 || bus.count !== 5'd1 || bus.m_data !== 8'h3C) begin
         failures++;
         $display("FAIL late_clear got pulses=%0d count=%0d data=%h want 1 1 3c",
                  pulses, bus.count, bus.m_data);
      end
      bus.m_ready = 1'b1;
      step();
      bus.m_ready = 1'b0;
      $display("late_clear: pulses=%0d", pulses);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      checks++;
      if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0) begin
         failures++;
         $display("FAIL fill got full=%b count=%0d ovf=%b want 1 16 0", bus.full, bus.count, bus.overflow);
      end
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'h55;
      step();
      checks++;
      if (bus.rx_rdy_clr !== 1'b1 || bus.overflow !== 1'b1 || bus.count !== 5'd16 || bus.m_data !== 8'h00) begin
         failures++;
         $display("FAIL overflow_drop got clr=%b ovf=%b count=%0d head=%h want 1 1 16 00",
                  bus.rx_rdy_clr, bus.overflow, bus.count, bus.m_data);
      end
      bus.rx_rdy = 1'b0;
      step();
      $display("overflow: full=%b ovf=%b", bus.full, bus.overflow);
   endtask

   task automatic test_ovf_clr();
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      checks++;
      if (bus.overflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clr_alone got ovf=%b want 0", bus.overflow);
      end
      // Clear and a fresh drop on the same edge: set wins.
      bus.ovf_clr = 1'b1;
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'h66;
      step();
      bus.ovf_clr = 1'b0;
      bus.rx_rdy  = 1'b0;
      checks++;
      if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
         failures++;
         $display("FAIL ovf_clr_vs_drop got ovf=%b count=%0d want 1 16", bus.overflow, bus.count);
      end
      step();
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      $display("ovf_clr: ovf=%b", bus.overflow);
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_q [$];
      bus.m_ready = 1'b1;
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'h77;
      step();
      bus.rx_rdy  = 1'b0;
      bus.m_ready = 1'b0;
      checks++;
      if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0 || bus.m_data !== 8'h01) begin
         failures++;
         $display("FAIL full_push_pop got count=%0d full=%b ovf=%b head=%h want 16 1 0 01",
                  bus.count, bus.full, bus.overflow, bus.m_data);
      end
      step();
      // Expected drain order: 01..0F then 77; 55 and 66 were dropped.
      for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'h77);
      bus.m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== exp_q[i]) begin
            failures++;
            $display("FAIL drain_%0d got valid=%b data=%h want 1 %h", i, bus.m_valid, bus.m_data, exp_q[i]);
         end
         step();
      end
      bus.m_ready = 1'b0;
      checks++;
      if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
         failures++;
         $display("FAIL drain_empty got empty=%b count=%0d want 1 0", bus.empty, bus.count);
      end
      $display("full_push_pop: drained 16 bytes, empty=%b", bus.empty);
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
      bus.rx_rdy  = 1'b1;
      bus.rx_data = 8'hC4;
      step();
      checks++;
      if (bus.count !== 5'd5 || bus.rx_rdy_clr !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset got count=%0d clr=%b want 5 1", bus.count, bus.rx_rdy_clr);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.m_valid !== 1'b0 ||
          bus.m_data !== 8'h00 || bus.overflow !== 1'b0 || bus.rx_rdy_clr !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got count=%0d empty=%b valid=%b data=%h ovf=%b clr=%b want 0 1 0 00 0 0",
                  bus.count, bus.empty, bus.m_valid, bus.m_data, bus.overflow, bus.rx_rdy_clr);
      end
      // Release with rx_rdy still high: captured as a new byte.
      bus.rx_data = 8'hD7;
      rst_n = 1'b1;
      step();
      checks++;
      if (bus.count !== 5'd1 || bus.rx_rdy_clr !== 1'b1 || bus.m_data !== 8'hD7) begin
         failures++;
         $display("FAIL post_reset_capture got count=%0d clr=%b data=%h want 1 1 d7",
                  bus.count, bus.rx_rdy_clr, bus.m_data);
      end
      bus.rx_rdy = 1'b0;
      step();
      $display("mid_reset: count=%0d head=%h", bus.count, bus.m_data);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single();
      test_late_clear();
      test_overflow();
      test_ovf_clr();
      test_full_push_pop();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
